// File: rtl/pitch_pkg.sv
// -----------------------------------------------------------------------------
// pitch_pkg
// Shared definitions for the pitch core datapath: the overlap-add FSM state
// type, the default grain geometry (also used by the Hann window generator and
// the pitch core) and the saturation helper used on the OLA output.
// -----------------------------------------------------------------------------
package pitch_pkg;

    // Default grain geometry shared across the pitch core
    localparam int DEFAULT_WIN_LEN = 256;
    localparam int DEFAULT_HOP     = 64;
    localparam int DEFAULT_DATA_W  = 16;

    // Working width of the saturation helper; any accumulator up to this
    // width is sign-extended into it before clamping
    localparam int SAT_IN_W = 32;

    typedef enum logic [1:0] {
        ACCUM,
        EMIT,
        FLUSH
    } ola_state_t;

    // Clamp a signed value to the signed range of a 'width'-bit word. The
    // result is returned at full working width; the caller keeps the low
    // 'width' bits, which hold the clamped two's complement value.
    function automatic logic signed [SAT_IN_W-1:0] sat_to_width(
        input logic signed [SAT_IN_W-1:0] acc,
        input int unsigned                width
    );
        logic signed [SAT_IN_W-1:0] maxV;
        logic signed [SAT_IN_W-1:0] minV;
        logic signed [SAT_IN_W-1:0] result;
        maxV = (SAT_IN_W'(1) << (width - 1)) - SAT_IN_W'(1);
        minV = ~maxV;
        if (acc > maxV) begin
            result = maxV;
        end else if (acc < minV) begin
            result = minV;
        end else begin
            result = acc;
        end
        return result;
    endfunction

endpackage

// File: rtl/ola_accum_ram.sv
// -----------------------------------------------------------------------------
// ola_accum_ram
// WIN_LEN x ACC_W circular accumulator storage for the overlap-add stage.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-low reset (zeroes array)
//   i_addEn/i_addAddr/
//   i_addData             read-modify-write add port: mem[addr] += data
//   i_rdAddr/o_rdData     combinational read of one slot
//   i_clrEn/i_clrAddr     clear one slot to zero
//   i_clrAll              clear every slot (end of a flush)
// Addresses are IDX_W bits wide, so modulo-WIN_LEN wrap comes from truncation
// in the caller's address arithmetic.
// -----------------------------------------------------------------------------
module ola_accum_ram
    import pitch_pkg::*;
#(
    parameter int WIN_LEN = DEFAULT_WIN_LEN,
    parameter int ACC_W   = DEFAULT_DATA_W + 3,
    localparam int IDX_W  = $clog2(WIN_LEN)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_addEn,
    input  logic [IDX_W-1:0]        i_addAddr,
    input  logic signed [ACC_W-1:0] i_addData,
    input  logic [IDX_W-1:0]        i_rdAddr,
    output logic signed [ACC_W-1:0] o_rdData,
    input  logic                    i_clrEn,
    input  logic [IDX_W-1:0]        i_clrAddr,
    input  logic                    i_clrAll
);

    logic signed [ACC_W-1:0] r_mem [WIN_LEN];

    assign o_rdData = r_mem[i_rdAddr];

    // The add port is only used while accumulating and the clear port only
    // while emitting, so the two never target the same slot in one cycle.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < WIN_LEN; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clrAll) begin
            for (int i = 0; i < WIN_LEN; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_addEn) begin
                r_mem[i_addAddr] <= r_mem[i_addAddr] + i_addData;
            end
            if (i_clrEn) begin
                r_mem[i_clrAddr] <= '0;
            end
        end
    end

endmodule

// File: rtl/pitch_ola_accumulator.sv
// -----------------------------------------------------------------------------
// pitch_ola_accumulator
// Overlap-add stage after the Hann-windowed grain generator. Each grain of
// WIN_LEN samples is summed into a circular accumulator starting at 'base';
// after every grain the HOP oldest slots are complete and are streamed out,
// saturated to DATA_W bits. A flush drains the remaining WIN_LEN-HOP slots.
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-low reset
//   in_valid/in_ready       grain sample handshake
//   in_sample, in_last      signed windowed sample, end-of-grain marker
//   out_valid/out_ready     output sample handshake
//   out_sample              saturated OLA sample (registered)
//   flush                   single-cycle drain request (honoured between grains)
//   flush_done              one-cycle pulse after the last drained sample
//   err                     sticky framing error, cleared only by reset
// -----------------------------------------------------------------------------
module pitch_ola_accumulator
    import pitch_pkg::*;
#(
    parameter int WIN_LEN = DEFAULT_WIN_LEN,
    parameter int HOP     = DEFAULT_HOP,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int ACC_W   = DATA_W + $clog2(WIN_LEN / HOP) + 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_sample,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sample,
    input  logic              flush,
    output logic              flush_done,
    output logic              err
);

    localparam int IDX_W = $clog2(WIN_LEN);

    localparam logic [IDX_W-1:0] ONE_IDX      = IDX_W'(1);
    localparam logic [IDX_W-1:0] HOP_IDX      = IDX_W'(HOP);
    localparam logic [IDX_W-1:0] K_LAST       = IDX_W'(WIN_LEN - 1);
    localparam logic [IDX_W-1:0] E_LAST_EMIT  = IDX_W'(HOP - 1);
    localparam logic [IDX_W-1:0] E_LAST_FLUSH = IDX_W'(WIN_LEN - HOP - 1);

    ola_state_t r_state;
    ola_state_t w_nextState;

    logic [IDX_W-1:0]        r_base;
    logic [IDX_W-1:0]        r_k;
    logic [IDX_W-1:0]        r_e;
    logic [IDX_W-1:0]        w_nextBase;
    logic [IDX_W-1:0]        w_nextK;
    logic [IDX_W-1:0]        w_nextE;
    logic                    r_outValid;
    logic                    w_nextOutValid;
    logic [DATA_W-1:0]       r_outSample;
    logic [DATA_W-1:0]       w_nextOutSample;
    logic                    r_flushDone;
    logic                    w_nextFlushDone;
    logic                    r_err;
    logic                    w_nextErr;

    logic                    w_inReady;
    logic                    w_addEn;
    logic                    w_clrEn;
    logic                    w_clrAll;
    logic                    w_kIsLast;
    logic [IDX_W-1:0]        w_addAddr;
    logic [IDX_W-1:0]        w_rdAddr;
    logic [IDX_W-1:0]        w_clrAddr;
    logic [IDX_W-1:0]        w_eLast;
    logic signed [ACC_W-1:0] w_addData;
    logic signed [ACC_W-1:0] w_rdData;
    logic signed [SAT_IN_W-1:0] w_satFull;
    logic [DATA_W-1:0]       w_satRd;
    logic                    w_unusedSatHigh;

    // Slot addresses wrap modulo WIN_LEN through IDX_W-bit truncation.
    // The read port looks one sample ahead: while accumulating it points at
    // the oldest slot (first output of the next emit/flush); while emitting it
    // points at the slot after the one currently presented.
    assign w_addAddr = r_base + r_k;
    assign w_clrAddr = r_base + r_e;
    assign w_rdAddr  = (r_state == ACCUM) ? r_base : (r_base + r_e + ONE_IDX);
    assign w_eLast   = (r_state == FLUSH) ? E_LAST_FLUSH : E_LAST_EMIT;
    assign w_kIsLast = (r_k == K_LAST);
    assign w_addData = ACC_W'($signed(in_sample));

    assign w_satFull       = sat_to_width(SAT_IN_W'(w_rdData), DATA_W);
    assign w_satRd         = w_satFull[DATA_W-1:0];
    assign w_unusedSatHigh = ^w_satFull[SAT_IN_W-1:DATA_W];

    ola_accum_ram #(
        .WIN_LEN (WIN_LEN),
        .ACC_W   (ACC_W)
    ) u_ram (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_addEn   (w_addEn),
        .i_addAddr (w_addAddr),
        .i_addData (w_addData),
        .i_rdAddr  (w_rdAddr),
        .o_rdData  (w_rdData),
        .i_clrEn   (w_clrEn),
        .i_clrAddr (w_clrAddr),
        .i_clrAll  (w_clrAll)
    );

    // State, pointers and registered outputs. Reset discards any partial
    // grain or partial emit and returns to an empty accumulator.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= ACCUM;
            r_base      <= '0;
            r_k         <= '0;
            r_e         <= '0;
            r_outValid  <= 1'b0;
            r_outSample <= '0;
            r_flushDone <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_base      <= w_nextBase;
            r_k         <= w_nextK;
            r_e         <= w_nextE;
            r_outValid  <= w_nextOutValid;
            r_outSample <= w_nextOutSample;
            r_flushDone <= w_nextFlushDone;
            r_err       <= w_nextErr;
        end
    end

    // Next-state and datapath control. A flush that is honoured in the same
    // cycle as a sample would start draining before that sample could land,
    // so in_ready drops for that one cycle and the sample waits.
    always_comb begin
        w_nextState     = r_state;
        w_nextBase      = r_base;
        w_nextK         = r_k;
        w_nextE         = r_e;
        w_nextOutValid  = r_outValid;
        w_nextOutSample = r_outSample;
        w_nextFlushDone = 1'b0;
        w_nextErr       = r_err;
        w_inReady       = 1'b0;
        w_addEn         = 1'b0;
        w_clrEn         = 1'b0;
        w_clrAll        = 1'b0;

        case (r_state)
            ACCUM: begin
                w_inReady = !(flush && (r_k == '0));
                if (flush) begin
                    if (r_k == '0) begin
                        w_nextState     = FLUSH;
                        w_nextE         = '0;
                        w_nextOutValid  = 1'b1;
                        w_nextOutSample = w_satRd;
                    end else begin
                        w_nextErr = 1'b1;
                    end
                end
                if (in_valid && w_inReady) begin
                    w_addEn = 1'b1;
                    if (in_last != w_kIsLast) begin
                        w_nextErr = 1'b1;
                    end
                    if (w_kIsLast) begin
                        w_nextK         = '0;
                        w_nextState     = EMIT;
                        w_nextE         = '0;
                        w_nextOutValid  = 1'b1;
                        w_nextOutSample = w_satRd;
                    end else begin
                        w_nextK = r_k + ONE_IDX;
                    end
                end
            end

            EMIT, FLUSH: begin
                if (r_outValid && out_ready) begin
                    w_clrEn = 1'b1;
                    if (r_e == w_eLast) begin
                        w_nextState     = ACCUM;
                        w_nextE         = '0;
                        w_nextOutValid  = 1'b0;
                        w_nextOutSample = '0;
                        if (r_state == FLUSH) begin
                            w_nextBase      = '0;
                            w_clrAll        = 1'b1;
                            w_nextFlushDone = 1'b1;
                        end else begin
                            w_nextBase = r_base + HOP_IDX;
                        end
                    end else begin
                        w_nextE         = r_e + ONE_IDX;
                        w_nextOutSample = w_satRd;
                    end
                end
            end

            default: begin
                w_nextState = ACCUM;
            end
        endcase
    end

    assign in_ready   = w_inReady;
    assign out_valid  = r_outValid;
    assign out_sample = r_outSample;
    assign flush_done = r_flushDone;
    assign err        = r_err;

endmodule
